// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS instruction-decode stage with a registered ID/EX output.
// Decodes one instruction per cycle, reads the register file, resolves BEQ/BNE
// in ID and handles load-use / RAW hazards with a valid/stall/flush handshake.
// Optional feature macro ID_FORWARD_EN: when defined, operands are forwarded from
// EX/MEM and only load-use stalls; when undefined, any RAW hit on EX or MEM stalls.
module id_stage_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  input  logic [31:0]         if_pc_i,
  input  logic [31:0]         if_inst_i,
  output logic                id_ready_o,
  output logic [RADDR_W-1:0]  rf_raddr1_o,
  output logic [RADDR_W-1:0]  rf_raddr2_o,
  input  logic [DATA_W-1:0]   rf_rdata1_i,
  input  logic [DATA_W-1:0]   rf_rdata2_i,
  input  logic                ex_wreg_i,
  input  logic [RADDR_W-1:0]  ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [RADDR_W-1:0]  mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                ex_stall_i,
  input  logic                flush_i,
  output logic                br_taken_o,
  output logic [31:0]         br_target_o,
  output logic                ex_valid_o,
  output logic [31:0]         ex_pc_o,
  output logic [ALUSEL_W-1:0] ex_alusel_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic [DATA_W-1:0]   ex_reg1_o,
  output logic [DATA_W-1:0]   ex_reg2_o,
  output logic [RADDR_W-1:0]  ex_wd_o,
  output logic                ex_wreg_o,
  output logic [DATA_W-1:0]   ex_store_o
);

  localparam logic [2:0] SelNop = 3'd0, SelLogic = 3'd1, SelShift = 3'd2, SelArith = 3'd3,
                         SelMem = 3'd4;
  localparam logic [7:0] OpAnd = 8'h24, OpOr = 8'h25, OpXor = 8'h26, OpAddu = 8'h21,
                         OpSlt = 8'h2A, OpLui = 8'h0F, OpLw = 8'hA3, OpSw = 8'hAB;

  logic [5:0]          opcode, funct;
  logic [4:0]          rs, rt, rd, sa;
  logic [15:0]         imm;
  logic [RADDR_W-1:0]  rs_a, rt_a;
  logic [DATA_W-1:0]   imm_sext, imm_zext, imm_lui, sa_zext;
  logic [DATA_W-1:0]   rs_val, rt_val;
  logic [ALUSEL_W-1:0] d_alusel;
  logic [ALUOP_W-1:0]  d_aluop;
  logic [DATA_W-1:0]   d_reg1, d_reg2, d_store;
  logic [RADDR_W-1:0]  d_wd;
  logic                d_wreg, use_rs, use_rt, is_beq, is_bne;
  logic                rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit, hazard, br_cond;

  assign opcode   = if_inst_i[31:26];
  assign rs       = if_inst_i[25:21];
  assign rt       = if_inst_i[20:16];
  assign rd       = if_inst_i[15:11];
  assign sa       = if_inst_i[10:6];
  assign funct    = if_inst_i[5:0];
  assign imm      = if_inst_i[15:0];
  assign rs_a     = RADDR_W'(rs);
  assign rt_a     = RADDR_W'(rt);
  assign imm_sext = DATA_W'($signed(imm));
  assign imm_zext = DATA_W'(imm);
  assign imm_lui  = DATA_W'({imm, 16'h0000});
  assign sa_zext  = DATA_W'(sa);

  assign rf_raddr1_o = rs_a;
  assign rf_raddr2_o = rt_a;

  // Operand fetch: r0 is hard zero; with forwarding EX beats MEM beats RF.
  always_comb begin
    rs_val = rf_rdata1_i;
    rt_val = rf_rdata2_i;
`ifdef ID_FORWARD_EN
    if (mem_wreg_i && (mem_wd_i == rs_a)) rs_val = mem_wdata_i;
    if (mem_wreg_i && (mem_wd_i == rt_a)) rt_val = mem_wdata_i;
    if (ex_wreg_i && (ex_wd_i == rs_a))   rs_val = ex_wdata_i;
    if (ex_wreg_i && (ex_wd_i == rt_a))   rt_val = ex_wdata_i;
`endif
    if (rs_a == '0) rs_val = '0;
    if (rt_a == '0) rt_val = '0;
  end

  // Instruction decode; anything unrecognised falls through as an all-zero NOP.
  always_comb begin
    d_alusel = '0;
    d_aluop  = '0;
    d_reg1   = '0;
    d_reg2   = '0;
    d_store  = '0;
    d_wd     = '0;
    d_wreg   = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23, 6'h2A: begin
            d_alusel = (funct[5:2] == 4'b1001) ? ALUSEL_W'(SelLogic) : ALUSEL_W'(SelArith);
            d_aluop  = ALUOP_W'(funct);
            d_reg1   = rs_val;
            d_reg2   = rt_val;
            d_wd     = RADDR_W'(rd);
            d_wreg   = 1'b1;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
          end
          6'h00, 6'h02, 6'h03: begin
            d_alusel = ALUSEL_W'(SelShift);
            d_aluop  = ALUOP_W'(funct);
            d_reg1   = sa_zext;
            d_reg2   = rt_val;
            d_wd     = RADDR_W'(rd);
            d_wreg   = 1'b1;
            use_rt   = 1'b1;
          end
          default: ;
        endcase
      end
      6'h0C, 6'h0D, 6'h0E: begin
        d_alusel = ALUSEL_W'(SelLogic);
        d_aluop  = (opcode == 6'h0C) ? ALUOP_W'(OpAnd) :
                   (opcode == 6'h0D) ? ALUOP_W'(OpOr) : ALUOP_W'(OpXor);
        d_reg1   = rs_val;
        d_reg2   = imm_zext;
        d_wd     = rt_a;
        d_wreg   = 1'b1;
        use_rs   = 1'b1;
      end
      6'h09, 6'h0A: begin
        d_alusel = ALUSEL_W'(SelArith);
        d_aluop  = (opcode == 6'h09) ? ALUOP_W'(OpAddu) : ALUOP_W'(OpSlt);
        d_reg1   = rs_val;
        d_reg2   = imm_sext;
        d_wd     = rt_a;
        d_wreg   = 1'b1;
        use_rs   = 1'b1;
      end
      6'h0F: begin
        d_alusel = ALUSEL_W'(SelLogic);
        d_aluop  = ALUOP_W'(OpLui);
        d_reg2   = imm_lui;
        d_wd     = rt_a;
        d_wreg   = 1'b1;
      end
      6'h23: begin
        d_alusel = ALUSEL_W'(SelMem);
        d_aluop  = ALUOP_W'(OpLw);
        d_reg1   = rs_val;
        d_reg2   = imm_sext;
        d_wd     = rt_a;
        d_wreg   = 1'b1;
        use_rs   = 1'b1;
      end
      6'h2B: begin
        d_alusel = ALUSEL_W'(SelMem);
        d_aluop  = ALUOP_W'(OpSw);
        d_reg1   = rs_val;
        d_reg2   = imm_sext;
        d_store  = rt_val;
        use_rs   = 1'b1;
        use_rt   = 1'b1;
      end
      6'h04, 6'h05: begin
        is_beq = (opcode == 6'h04);
        is_bne = (opcode == 6'h05);
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: d_alusel = ALUSEL_W'(SelNop);
    endcase
  end

  assign rs_ex_hit  = use_rs && (rs_a != '0) && ex_wreg_i && (ex_wd_i == rs_a);
  assign rt_ex_hit  = use_rt && (rt_a != '0) && ex_wreg_i && (ex_wd_i == rt_a);
  assign rs_mem_hit = use_rs && (rs_a != '0) && mem_wreg_i && (mem_wd_i == rs_a);
  assign rt_mem_hit = use_rt && (rt_a != '0) && mem_wreg_i && (mem_wd_i == rt_a);

`ifdef ID_FORWARD_EN
  // Only a load in EX has no data yet; everything else is forwarded.
  assign hazard = ex_is_load_i && (rs_ex_hit || rt_ex_hit);
`else
  // Without forwarding wait until the writer has left MEM and reached the RF.
  assign hazard = rs_ex_hit || rt_ex_hit || rs_mem_hit || rt_mem_hit;
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

  assign id_ready_o  = !ex_stall_i && !hazard;
  assign br_cond     = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
  assign br_taken_o  = !rst && if_valid_i && id_ready_o && br_cond;
  assign br_target_o = if_pc_i + 32'd4 + {{14{imm[15]}}, imm, 2'b00};

  // ID/EX register: flush beats stall beats hazard bubble beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o  <= 1'b0;
      ex_pc_o     <= '0;
      ex_alusel_o <= '0;
      ex_aluop_o  <= '0;
      ex_reg1_o   <= '0;
      ex_reg2_o   <= '0;
      ex_wd_o     <= '0;
      ex_wreg_o   <= 1'b0;
      ex_store_o  <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (ex_stall_i) begin
      ex_valid_o <= ex_valid_o;
    end else if (hazard) begin
      ex_valid_o <= 1'b0;
    end else begin
      ex_valid_o  <= if_valid_i;
      ex_pc_o     <= if_pc_i;
      ex_alusel_o <= d_alusel;
      ex_aluop_o  <= d_aluop;
      ex_reg1_o   <= d_reg1;
      ex_reg2_o   <= d_reg2;
      ex_wd_o     <= d_wd;
      ex_wreg_o   <= d_wreg;
      ex_store_o  <= d_store;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: stimulus pushes expected ID/EX contents,
// a monitor pops and compares whenever a freshly loaded valid entry appears.
module tb_id_stage_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] st;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0, if_inst_i = '0;
  logic        id_ready_o;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic        ex_wreg_i = 1'b0, ex_is_load_i = 1'b0, mem_wreg_i = 1'b0;
  logic [4:0]  ex_wd_i = '0, mem_wd_i = '0;
  logic [31:0] ex_wdata_i = '0, mem_wdata_i = '0;
  logic        ex_stall_i = 1'b0, flush_i = 1'b0;
  logic        br_taken_o, ex_valid_o, ex_wreg_o;
  logic [31:0] br_target_o, ex_pc_o, ex_reg1_o, ex_reg2_o, ex_store_o;
  logic [2:0]  ex_alusel_o;
  logic [7:0]  ex_aluop_o;
  logic [4:0]  ex_wd_o;

  logic [31:0] rf [32];
  exp_t        sb [$];
  int          n_vec = 0, n_err = 0;

  assign rf_rdata1_i = rf[rf_raddr1_o];
  assign rf_rdata2_i = rf[rf_raddr2_o];

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .id_ready_o(id_ready_o), .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i), .ex_wreg_i(ex_wreg_i),
    .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .ex_stall_i(ex_stall_i), .flush_i(flush_i), .br_taken_o(br_taken_o),
    .br_target_o(br_target_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_alusel_o(ex_alusel_o), .ex_aluop_o(ex_aluop_o), .ex_reg1_o(ex_reg1_o),
    .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_store_o(ex_store_o)
  );

  function automatic logic [31:0] rtype(input logic [4:0] s, t, d, a, input logic [5:0] f);
    return {6'h00, s, t, d, a, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s, t,
                                        input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] sel,
                              input logic [7:0] op, input logic [31:0] r1, r2,
                              input logic [4:0] wd, input logic wreg, input logic [31:0] st);
    exp_t e;
    e.pc = pc; e.sel = sel; e.op = op; e.r1 = r1; e.r2 = r2; e.wd = wd; e.wreg = wreg;
    e.st = st;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
  endtask

  function automatic logic any_out();
    return |{ex_valid_o, ex_pc_o, ex_alusel_o, ex_aluop_o, ex_reg1_o, ex_reg2_o, ex_wd_o,
             ex_wreg_o, ex_store_o, br_taken_o};
  endfunction

  // Monitor: an entry is new when the edge that produced it had no stall/flush/reset.
  initial begin : monitor
    exp_t e, a;
    logic st, fl, r;
    forever begin
      @(posedge clk);
      st = ex_stall_i;
      fl = flush_i;
      r  = rst;
      @(negedge clk);
      if (!r && !rst && !st && !fl && ex_valid_o) begin
        a = mk(ex_pc_o, ex_alusel_o, ex_aluop_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
               ex_store_o);
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL idex_unexpected: got valid entry pc=%h, want none", ex_pc_o);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL idex_out pc=%h: got sel=%0d op=%h r1=%h r2=%h wd=%0d wreg=%0d st=%h, want pc=%h sel=%0d op=%h r1=%h r2=%h wd=%0d wreg=%0d st=%h",
                     a.pc, a.sel, a.op, a.r1, a.r2, a.wd, a.wreg, a.st,
                     e.pc, e.sel, e.op, e.r1, e.r2, e.wd, e.wreg, e.st);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  logic [31:0] vi [15];
  exp_t        ve [15];

  initial begin : stim
    exp_t e;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'd7;
    rf[2] = 32'd8;
    rf[3] = 32'h11;
    rf[5] = 32'h22;

    // Reset with an ORI presented; nothing may leak out until release.
    drive(32'h0, itype(6'h0D, 5'd0, 5'd1, 16'h1234));
    repeat (3) begin
      @(negedge clk);
      chk("reset_zero", {31'b0, any_out()}, 32'd0);
    end
    sb.push_back(mk(32'h0, 3'd1, 8'h25, 32'h0, 32'h1234, 5'd1, 1'b1, 32'h0));
    rst = 1'b0;
    step();
    if_valid_i = 1'b0;

    // RAW on an ADDU sitting in EX.
    drive(32'h10, rtype(5'd3, 5'd3, 5'd4, 5'd0, 6'h24));
    ex_wreg_i = 1'b1; ex_wd_i = 5'd3; ex_wdata_i = 32'h55;
    #1;
`ifdef ID_FORWARD_EN
    chk("fwd_ex_ready", {31'b0, id_ready_o}, 32'd1);
    sb.push_back(mk(32'h10, 3'd1, 8'h24, 32'h55, 32'h55, 5'd4, 1'b1, 32'h0));
    step();
    // EX result beats an older MEM result for the same register.
    drive(32'h14, rtype(5'd3, 5'd0, 5'd4, 5'd0, 6'h25));
    mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'h66;
    sb.push_back(mk(32'h14, 3'd1, 8'h25, 32'h55, 32'h0, 5'd4, 1'b1, 32'h0));
    step();
    ex_wreg_i = 1'b0;
    sb.push_back(mk(32'h14, 3'd1, 8'h25, 32'h66, 32'h0, 5'd4, 1'b1, 32'h0));
    step();
`else
    chk("raw_ex_stall", {31'b0, id_ready_o}, 32'd0);
    step();
    chk("raw_bubble1", {31'b0, ex_valid_o}, 32'd0);
    ex_wreg_i = 1'b0; mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'h55;
    #1;
    chk("raw_mem_stall", {31'b0, id_ready_o}, 32'd0);
    step();
    chk("raw_bubble2", {31'b0, ex_valid_o}, 32'd0);
    mem_wreg_i = 1'b0; rf[3] = 32'h55;
    #1;
    chk("raw_release", {31'b0, id_ready_o}, 32'd1);
    sb.push_back(mk(32'h10, 3'd1, 8'h24, 32'h55, 32'h55, 5'd4, 1'b1, 32'h0));
    step();
`endif
    if_valid_i = 1'b0; ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;

    // Load-use: LW r5 in EX, ADDU r6,r5,r0 in ID.
    drive(32'h20, rtype(5'd5, 5'd0, 5'd6, 5'd0, 6'h21));
    ex_wreg_i = 1'b1; ex_wd_i = 5'd5; ex_is_load_i = 1'b1; ex_wdata_i = 32'hBAD;
    #1;
    chk("lu_stall", {31'b0, id_ready_o}, 32'd0);
    step();
    chk("lu_bubble", {31'b0, ex_valid_o}, 32'd0);
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd5; mem_wdata_i = 32'h77;
`ifndef ID_FORWARD_EN
    #1;
    chk("lu_mem_stall", {31'b0, id_ready_o}, 32'd0);
    step();
    mem_wreg_i = 1'b0; rf[5] = 32'h77;
`endif
    #1;
    chk("lu_issue", {31'b0, id_ready_o}, 32'd1);
    sb.push_back(mk(32'h20, 3'd3, 8'h21, 32'h77, 32'h0, 5'd6, 1'b1, 32'h0));
    step();
    if_valid_i = 1'b0; mem_wreg_i = 1'b0;

    // Branches resolve in ID and flow down as NOPs.
    rf[2] = 32'd7;
    drive(32'h100, itype(6'h04, 5'd1, 5'd2, 16'h0004));
    #1;
    chk("beq_taken", {31'b0, br_taken_o}, 32'd1);
    chk("beq_target", br_target_o, 32'h114);
    sb.push_back(mk(32'h100, 3'd0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0));
    step();
    rf[2] = 32'd8;
    drive(32'h104, itype(6'h04, 5'd1, 5'd2, 16'h0004));
    #1;
    chk("beq_not_taken", {31'b0, br_taken_o}, 32'd0);
    chk("beq_target2", br_target_o, 32'h118);
    sb.push_back(mk(32'h104, 3'd0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0));
    step();
    drive(32'h200, itype(6'h05, 5'd1, 5'd2, 16'hFFFF));
    #1;
    chk("bne_taken", {31'b0, br_taken_o}, 32'd1);
    chk("bne_back_target", br_target_o, 32'h200);
    sb.push_back(mk(32'h200, 3'd0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0));
    step();
    drive(32'h204, itype(6'h05, 5'd1, 5'd2, 16'hFFFF));
    ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_is_load_i = 1'b1;
    #1;
    chk("br_lu_stall", {31'b0, id_ready_o}, 32'd0);
    chk("br_lu_no_take", {31'b0, br_taken_o}, 32'd0);
    step();
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0; if_valid_i = 1'b0;
    #1;
    chk("br_invalid_no_take", {31'b0, br_taken_o}, 32'd0);

    // Back-to-back decode table, r1=7 r2=8.
    vi[0]  = rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h25);
    ve[0]  = mk(0, 3'd1, 8'h25, 32'd7, 32'd8, 5'd13, 1'b1, 0);
    vi[1]  = rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h27);
    ve[1]  = mk(0, 3'd1, 8'h27, 32'd7, 32'd8, 5'd13, 1'b1, 0);
    vi[2]  = rtype(5'd2, 5'd1, 5'd14, 5'd0, 6'h23);
    ve[2]  = mk(0, 3'd3, 8'h23, 32'd8, 32'd7, 5'd14, 1'b1, 0);
    vi[3]  = rtype(5'd1, 5'd2, 5'd15, 5'd0, 6'h2A);
    ve[3]  = mk(0, 3'd3, 8'h2A, 32'd7, 32'd8, 5'd15, 1'b1, 0);
    vi[4]  = rtype(5'd0, 5'd1, 5'd9, 5'd4, 6'h00);
    ve[4]  = mk(0, 3'd2, 8'h00, 32'd4, 32'd7, 5'd9, 1'b1, 0);
    vi[5]  = rtype(5'd0, 5'd2, 5'd9, 5'd31, 6'h03);
    ve[5]  = mk(0, 3'd2, 8'h03, 32'd31, 32'd8, 5'd9, 1'b1, 0);
    vi[6]  = rtype(5'd0, 5'd2, 5'd9, 5'd1, 6'h02);
    ve[6]  = mk(0, 3'd2, 8'h02, 32'd1, 32'd8, 5'd9, 1'b1, 0);
    vi[7]  = itype(6'h0C, 5'd1, 5'd16, 16'hFFFF);
    ve[7]  = mk(0, 3'd1, 8'h24, 32'd7, 32'h0000_FFFF, 5'd16, 1'b1, 0);
    vi[8]  = itype(6'h09, 5'd1, 5'd17, 16'hFFFF);
    ve[8]  = mk(0, 3'd3, 8'h21, 32'd7, 32'hFFFF_FFFF, 5'd17, 1'b1, 0);
    vi[9]  = itype(6'h0A, 5'd2, 5'd18, 16'h8000);
    ve[9]  = mk(0, 3'd3, 8'h2A, 32'd8, 32'hFFFF_8000, 5'd18, 1'b1, 0);
    vi[10] = itype(6'h0F, 5'd0, 5'd10, 16'hABCD);
    ve[10] = mk(0, 3'd1, 8'h0F, 32'd0, 32'hABCD_0000, 5'd10, 1'b1, 0);
    vi[11] = itype(6'h23, 5'd1, 5'd19, 16'hFFFC);
    ve[11] = mk(0, 3'd4, 8'hA3, 32'd7, 32'hFFFF_FFFC, 5'd19, 1'b1, 0);
    vi[12] = itype(6'h2B, 5'd1, 5'd2, 16'h0008);
    ve[12] = mk(0, 3'd4, 8'hAB, 32'd7, 32'd8, 5'd0, 1'b0, 32'd8);
    vi[13] = rtype(5'd0, 5'd2, 5'd20, 5'd0, 6'h26);
    ve[13] = mk(0, 3'd1, 8'h26, 32'd0, 32'd8, 5'd20, 1'b1, 0);
    vi[14] = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
    ve[14] = mk(0, 3'd0, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 0);
    for (int i = 0; i < 15; i++) begin
      e = ve[i];
      e.pc = 32'h300 + 32'(i * 4);
      drive(e.pc, vi[i]);
      sb.push_back(e);
      step();
    end

    // Stall holds, flush during stall kills the entry.
    drive(32'h400, itype(6'h0E, 5'd1, 5'd7, 16'h00F0));
    sb.push_back(mk(32'h400, 3'd1, 8'h26, 32'd7, 32'hF0, 5'd7, 1'b1, 0));
    step();
    drive(32'h404, itype(6'h0D, 5'd0, 5'd8, 16'h0005));
    ex_stall_i = 1'b1;
    #1;
    chk("stall_ready", {31'b0, id_ready_o}, 32'd0);
    step();
    chk("stall_hold_valid", {31'b0, ex_valid_o}, 32'd1);
    chk("stall_hold_pc", ex_pc_o, 32'h400);
    chk("stall_hold_reg2", ex_reg2_o, 32'hF0);
    flush_i = 1'b1;
    step();
    chk("flush_valid", {31'b0, ex_valid_o}, 32'd0);
    ex_stall_i = 1'b0; flush_i = 1'b0;
    sb.push_back(mk(32'h404, 3'd1, 8'h25, 32'd0, 32'd5, 5'd8, 1'b1, 0));
    step();

    // Asynchronous reset in the middle of a stall with a pending load-use hazard.
    drive(32'h500, rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h21));
    ex_stall_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_is_load_i = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("async_reset_zero", {31'b0, any_out()}, 32'd0);
    @(negedge clk);
    rst = 1'b0; ex_stall_i = 1'b0; ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    #1;
    chk("post_reset_ready", {31'b0, id_ready_o}, 32'd1);
    sb.push_back(mk(32'h500, 3'd3, 8'h21, 32'd7, 32'd8, 5'd12, 1'b1, 0));
    step();

    // Unknown opcode still flows down as a valid NOP.
    drive(32'h600, itype(6'h3F, 5'd1, 5'd2, 16'h1234));
    sb.push_back(mk(32'h600, 3'd0, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 0));
    step();
    chk("unk_valid", {31'b0, ex_valid_o}, 32'd1);
    chk("unk_wreg", {31'b0, ex_wreg_o}, 32'd0);
    if_valid_i = 1'b0;

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
